hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5, busy cycles of a mult/multu after it leaves E.
REQ-002 Parameter DIV_CYC, default 10, busy cycles of a div/divu after it leaves E.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low; 0 clears all state immediately.
REQ-005 rs_D, rt_D  in  5 each  source register numbers of the instruction in D.
REQ-006 tuse_rs_D, tuse_rt_D  in  2 each  cycles until D needs rs/rt; 3 = not used.
REQ-007 md_use_D  in  1  D holds mult/div/mfhi/mflo/mthi/mtlo.
REQ-008 RDst_E, RDst_M  in  5 each  destination register in E/M; 0 = none.
REQ-009 tnew_E, tnew_M  in  2 each  cycles until E/M result is available (remaining count at that stage).
REQ-010 md_start_E  in  1  mult/div issuing in E this cycle; md_div_E  in  1  1 = div, 0 = mult.
REQ-011 pc_en  out  1  PC write enable.
REQ-012 d_en  out  1  F/D pipe register enable.
REQ-013 e_clr  out  1  synchronous clear (bubble) of D/E pipe register.
REQ-014 md_busy  out  1  HI/LO unit busy.
REQ-015 fwd_rs_D, fwd_rt_D  out  2 each  D operand source: 0 GRF, 1 E (PC8), 2 M (ALUout), 3 reserved.

Function
REQ-016 stall_rs SHALL be 1 when rs_D!=0 and ((rs_D==RDst_E and tuse_rs_D<tnew_E) or (rs_D==RDst_M and tuse_rs_D<tnew_M)); stall_rt identical for rt.
REQ-017 stall_md SHALL be 1 when md_use_D and (md_busy or md_start_E).
REQ-018 stall = stall_rs | stall_rt | stall_md; pc_en = d_en = !stall; e_clr = stall; all combinational, same cycle.
REQ-019 fwd_rs_D SHALL be 1 if rs_D!=0, rs_D==RDst_E, tnew_E==0; else 2 if rs_D!=0, rs_D==RDst_M, tnew_M==0; else 0 (E priority over M); fwd_rt_D identical.
REQ-020 FSM states IDLE, BUSY; 16-bit-max down counter cnt (width from max(MULT_CYC,DIV_CYC)).
REQ-021 IDLE: md_start_E -> load cnt = DIV_CYC if md_div_E else MULT_CYC, go BUSY.
REQ-022 BUSY: cnt decrements each edge; cnt reaching 1 -> IDLE at next edge; md_busy = 1 for exactly N cycles after the start cycle.
REQ-023 md_busy SHALL be (state==BUSY) registered; start cycle covered by md_start_E term of REQ-017.
REQ-024 md_start_E in BUSY (protocol violation) SHALL reload cnt with new N and remain BUSY.
REQ-025 Parameter value 0 SHALL be treated as 1.

Reset
REQ-026 reset low: state=IDLE, cnt=0, md_busy=0 asynchronously; combinational outputs follow inputs.
REQ-027 reset asserted mid-BUSY SHALL abort the count; after release, no stall_md without a new start.

Structure
REQ-028 Shared package: FSM state encoding, forwarding-select constants (FWD_GRF/E/M), tuse/tnew encoding, MULT_CYC/DIV_CYC defaults.
REQ-029 One sub-module md_timer (FSM+counter, REQ-020..025); stall/forward logic stays in top.

Verification
REQ-030 rs_D=5, tuse_rs_D=0, RDst_E=5, tnew_E=2 -> pc_en=0, d_en=0, e_clr=1 that cycle.
REQ-031 rs_D=0, RDst_E=0, tnew_E=2 -> no stall, fwd_rs_D=0.
REQ-032 rt_D=7 matches RDst_E and RDst_M, both tnew=0 -> fwd_rt_D=1, no stall.
REQ-033 md_start_E=1, md_div_E=0 at cycle t, mflo in D t..t+6 -> stall t..t+5, pc_en=1 at t+6.
REQ-034 div start at t, reset low at t+3 for 1 cycle -> md_busy=0 immediately, no stall after release.
REQ-035 md_use_D=1, md_busy=0, md_start_E=0 -> no stall.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: multiply/divide timer
// state encoding, forwarding selects, tuse/tnew encoding and default latencies.
package hazard_ctrl_pkg;

    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    localparam logic [1:0] FWD_GRF  = 2'd0;
    localparam logic [1:0] FWD_E    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;
    localparam logic [1:0] FWD_RSVD = 2'd3;

    // tuse of 3 means the operand is never read, so it can never trail a producer.
    localparam logic [1:0] TUSE_NONE  = 2'd3;
    localparam logic [1:0] TNEW_READY = 2'd0;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    function automatic int eff_cyc(input int n);
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle of decode/execute/memory hazard information and the
// resulting stall and forwarding controls.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic [4:0] rs_D;
    logic [4:0] rt_D;
    logic [1:0] tuse_rs_D;
    logic [1:0] tuse_rt_D;
    logic       md_use_D;
    logic [4:0] RDst_E;
    logic [4:0] RDst_M;
    logic [1:0] tnew_E;
    logic [1:0] tnew_M;
    logic       md_start_E;
    logic       md_div_E;

    logic       pc_en;
    logic       d_en;
    logic       e_clr;
    logic       md_busy;
    logic [1:0] fwd_rs_D;
    logic [1:0] fwd_rt_D;
    logic [0:0] md_state;

    // No valid/ready pair: md_start_E is a single-cycle pulse with md_div_E
    // qualified by it; every other input is a level sampled in the same cycle.
    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
        output RDst_E, RDst_M, tnew_E, tnew_M, md_start_E, md_div_E,
        input  pc_en, d_en, e_clr, md_busy, fwd_rs_D, fwd_rt_D, md_state
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, md_use_D,
        input  RDst_E, RDst_M, tnew_E, tnew_M, md_start_E, md_div_E,
        output pc_en, d_en, e_clr, md_busy, fwd_rs_D, fwd_rt_D, md_state
    );

endinterface

// File: rtl/hazard_ctrl_md_timer.sv
// HI/LO unit occupancy timer: counts the busy cycles of a mult/div after it
// leaves E; busy is high for exactly N cycles following the start cycle.
module md_timer
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       is_div,
    output logic       busy,
    output logic [0:0] state_dbg
);

    localparam int MULT_N = eff_cyc(MULT_CYC);
    localparam int DIV_N  = eff_cyc(DIV_CYC);
    localparam int MAX_N  = (MULT_N > DIV_N) ? MULT_N : DIV_N;
    localparam int CNT_W  = $clog2(MAX_N + 1);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_N);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_N);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;

    // A start while already busy restarts the count with the new latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else if (start) begin
            state <= MD_BUSY;
            cnt   <= is_div ? DIV_LD : MULT_LD;
        end else if (state == MD_BUSY) begin
            if (cnt == CNT_ONE) begin
                state <= MD_IDLE;
                cnt   <= '0;
            end else begin
                cnt <= cnt - CNT_ONE;
            end
        end
    end

    assign busy      = (state == MD_BUSY);
    assign state_dbg = state;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: decode-stage stall decision, bubble insertion
// and operand forwarding selects, plus the HI/LO busy timer.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave bus
);

    logic       stall_rs;
    logic       stall_rt;
    logic       stall_md;
    logic       stall;
    logic       md_busy;
    logic [0:0] md_state;

    md_timer #(
        .MULT_CYC (MULT_CYC),
        .DIV_CYC  (DIV_CYC)
    ) u_md_timer (
        .clk       (clk),
        .reset     (reset),
        .start     (bus.md_start_E),
        .is_div    (bus.md_div_E),
        .busy      (md_busy),
        .state_dbg (md_state)
    );

    // A source must wait when a later stage will write it later than D needs it.
    function automatic logic src_stall(
        input logic [4:0] src, input logic [1:0] tuse,
        input logic [4:0] dst_e, input logic [1:0] tnew_e,
        input logic [4:0] dst_m, input logic [1:0] tnew_m
    );
        return (src != 5'd0) &&
               (((src == dst_e) && (tuse < tnew_e)) ||
                ((src == dst_m) && (tuse < tnew_m)));
    endfunction

    function automatic logic [1:0] src_fwd(
        input logic [4:0] src,
        input logic [4:0] dst_e, input logic [1:0] tnew_e,
        input logic [4:0] dst_m, input logic [1:0] tnew_m
    );
        if ((src != 5'd0) && (src == dst_e) && (tnew_e == TNEW_READY))
            return FWD_E;
        else if ((src != 5'd0) && (src == dst_m) && (tnew_m == TNEW_READY))
            return FWD_M;
        else
            return FWD_GRF;
    endfunction

    always_comb begin
        stall_rs = src_stall(bus.rs_D, bus.tuse_rs_D, bus.RDst_E, bus.tnew_E,
                             bus.RDst_M, bus.tnew_M);
        stall_rt = src_stall(bus.rt_D, bus.tuse_rt_D, bus.RDst_E, bus.tnew_E,
                             bus.RDst_M, bus.tnew_M);
        // The start cycle itself is covered by md_start_E; md_busy covers the rest.
        stall_md = bus.md_use_D && (md_busy || bus.md_start_E);
        stall    = stall_rs || stall_rt || stall_md;
    end

    assign bus.pc_en    = !stall;
    assign bus.d_en     = !stall;
    assign bus.e_clr    = stall;
    assign bus.md_busy  = md_busy;
    assign bus.md_state = md_state;
    assign bus.fwd_rs_D = src_fwd(bus.rs_D, bus.RDst_E, bus.tnew_E, bus.RDst_M, bus.tnew_M);
    assign bus.fwd_rt_D = src_fwd(bus.rt_D, bus.RDst_E, bus.tnew_E, bus.RDst_M, bus.tnew_M);

endmodule
